// File: rtl/lsu_pkg.sv
// Shared widths, funct3 codes, FSM states and request-check helpers for the load/store unit.
package lsu_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned BYTE_SIZE = 8;
    localparam int unsigned LANES     = XLEN / BYTE_SIZE;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef logic [LANES-1:0][BYTE_SIZE-1:0] lane_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_H, F3_HU: return addr_lo[0];
            F3_W:        return (addr_lo != 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

    // Unsupported width codes, and the unsigned forms which only exist for loads.
    function automatic logic is_illegal(input logic [2:0] funct3, input logic write);
        case (funct3)
            F3_B, F3_H, F3_W: return 1'b0;
            F3_BU, F3_HU:     return write;
            default:          return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane datapath: load extract/extend and sub-word store merge.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_byte_off,
    input  lane_word_t      i_rdata,
    input  logic [XLEN-1:0] i_wdata,
    output logic [XLEN-1:0] o_load_data_c,
    output lane_word_t      o_store_word_c
);

    logic [BYTE_SIZE-1:0]   w_byte;
    logic [2*BYTE_SIZE-1:0] w_half;

    // Load path: pick the addressed lane(s) and extend to XLEN.
    always_comb begin
        w_byte = i_rdata[i_byte_off];
        w_half = {i_rdata[{i_byte_off[1], 1'b1}], i_rdata[{i_byte_off[1], 1'b0}]};
        o_load_data_c = '0;
        case (i_funct3)
            F3_B:    o_load_data_c = {{(XLEN-BYTE_SIZE){w_byte[BYTE_SIZE-1]}}, w_byte};
            F3_BU:   o_load_data_c = {{(XLEN-BYTE_SIZE){1'b0}}, w_byte};
            F3_H:    o_load_data_c = {{(XLEN-2*BYTE_SIZE){w_half[2*BYTE_SIZE-1]}}, w_half};
            F3_HU:   o_load_data_c = {{(XLEN-2*BYTE_SIZE){1'b0}}, w_half};
            F3_W:    o_load_data_c = XLEN'(i_rdata);
            default: o_load_data_c = '0;
        endcase
    end

    // Store path: overlay the right-aligned store data onto the word read back.
    always_comb begin
        o_store_word_c = i_rdata;
        case (i_funct3)
            F3_B: o_store_word_c[i_byte_off] = i_wdata[BYTE_SIZE-1:0];
            F3_H: begin
                o_store_word_c[{i_byte_off[1], 1'b0}] = i_wdata[BYTE_SIZE-1:0];
                o_store_word_c[{i_byte_off[1], 1'b1}] = i_wdata[2*BYTE_SIZE-1:BYTE_SIZE];
            end
            F3_W:    o_store_word_c = lane_word_t'(i_wdata);
            default: o_store_word_c = i_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one execute-stage request at a time into word accesses on the data memory,
// using read-modify-write for sub-word stores since the memory has no byte enables.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic            resp_error,
    output logic [XLEN-1:0] resp_rdata,
    output logic            mem_read_enable,
    output logic            mem_write_enable,
    output logic [XLEN-1:0] mem_read_addr,
    output logic [XLEN-1:0] mem_write_addr,
    output lane_word_t      mem_write_data,
    input  lane_word_t      mem_read_data
);

    lsu_state_t      r_state;
    logic            r_write;
    logic [2:0]      r_funct3;
    logic [1:0]      r_byte_off;
    logic [XLEN-1:0] r_wdata;

    logic            w_accept;
    logic            w_req_err;
    logic [XLEN-1:0] w_word_idx;
    logic [XLEN-1:0] w_load_data;
    lane_word_t      w_store_word;

    assign w_accept   = req_valid && req_ready;
    assign w_req_err  = is_misaligned(req_funct3, req_addr[1:0]) || is_illegal(req_funct3, req_write);
    assign w_word_idx = XLEN'(req_addr >> 2);

    lsu_lane_align u_lane_align (
        .i_funct3      (r_funct3),
        .i_byte_off    (r_byte_off),
        .i_rdata       (mem_read_data),
        .i_wdata       (r_wdata),
        .o_load_data_c (w_load_data),
        .o_store_word_c(w_store_word)
    );

    // Control FSM; every output is a register so memory sees clean enables.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= IDLE;
            r_write          <= 1'b0;
            r_funct3         <= 3'b000;
            r_byte_off       <= 2'b00;
            r_wdata          <= '0;
            req_ready        <= 1'b1;
            resp_valid       <= 1'b0;
            resp_error       <= 1'b0;
            resp_rdata       <= '0;
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_read_addr    <= '0;
            mem_write_addr   <= '0;
            mem_write_data   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_write    <= req_write;
                        r_funct3   <= req_funct3;
                        r_byte_off <= req_addr[1:0];
                        r_wdata    <= req_wdata;
                        req_ready  <= 1'b0;
                        if (w_req_err) begin
                            r_state    <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= '0;
                        end else if (req_write && (req_funct3 == F3_W)) begin
                            r_state          <= WRITE;
                            mem_write_enable <= 1'b1;
                            mem_write_addr   <= w_word_idx;
                            mem_write_data   <= lane_word_t'(req_wdata);
                        end else begin
                            // Loads and sub-word stores both start with a read.
                            r_state         <= READ;
                            mem_read_enable <= 1'b1;
                            mem_read_addr   <= w_word_idx;
                            mem_write_addr  <= w_word_idx;
                        end
                    end
                end
                READ: begin
                    mem_read_enable <= 1'b0;
                    if (r_write) begin
                        r_state          <= WRITE;
                        mem_write_enable <= 1'b1;
                        mem_write_data   <= w_store_word;
                    end else begin
                        r_state    <= RESP;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b0;
                        resp_rdata <= w_load_data;
                    end
                end
                WRITE: begin
                    mem_write_enable <= 1'b0;
                    r_state          <= RESP;
                    resp_valid       <= 1'b1;
                    resp_error       <= 1'b0;
                    resp_rdata       <= '0;
                end
                RESP: begin
                    r_state    <= IDLE;
                    resp_valid <= 1'b0;
                    resp_error <= 1'b0;
                    resp_rdata <= '0;
                    req_ready  <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory model, per-cycle protocol/model checker, directed vectors.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_error;
    logic [31:0] resp_rdata;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic [31:0] mem_read_addr;
    logic [31:0] mem_write_addr;
    lane_word_t  mem_write_data;
    lane_word_t  mem_read_data;

    int total = 0;
    int bad   = 0;

    load_store_unit dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_error      (resp_error),
        .resp_rdata      (resp_rdata),
        .mem_read_enable (mem_read_enable),
        .mem_write_enable(mem_write_enable),
        .mem_read_addr   (mem_read_addr),
        .mem_write_addr  (mem_write_addr),
        .mem_write_data  (mem_write_data),
        .mem_read_data   (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Data memory: combinational read, write on the clock edge; preload port for the bench.
    logic [31:0] mem [0:63];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;

    assign mem_read_data = lane_word_t'(mem[mem_read_addr[5:0]]);

    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_val;
        else if (mem_write_enable) mem[mem_write_addr[5:0]] <= mem_write_data;
    end

    // Reference model state: expected memory contents and the one outstanding transaction.
    logic [31:0] ref_mem [0:63];
    int          ncyc = 0;
    int          acc_n = 0;
    int          resp_n = 0;
    bit          pending = 0;
    bit          e_err, e_ren, e_wen;
    int          e_lat;
    logic [31:0] e_rdata, e_idx, e_wdata;
    int          m_sz, m_sh;
    logic [31:0] m_w, m_mask, m_v;
    bit          m_ill;

    always @(negedge clk) begin
        ncyc = ncyc + 1;
        if (pre_en) ref_mem[pre_idx] = pre_val;
        if (reset) begin
            pending = 0;
        end else begin
            check("one_enable", {31'b0, mem_read_enable & mem_write_enable}, 32'd0);
            if (mem_read_enable) begin
                if (pending && e_ren) begin
                    check("rd_addr", mem_read_addr, e_idx);
                    check("rd_cycle", ncyc - acc_n, 32'd1);
                    e_ren = 0;
                end else check("rd_unexpected", 32'd1, 32'd0);
            end
            if (mem_write_enable) begin
                if (pending && e_wen) begin
                    check("wr_addr", mem_write_addr, e_idx);
                    check("wr_data", mem_write_data, e_wdata);
                    check("wr_cycle", ncyc - acc_n, e_lat - 1);
                    ref_mem[e_idx[5:0]] = e_wdata;
                    e_wen = 0;
                end else check("wr_unexpected", 32'd1, 32'd0);
            end
            if (resp_valid) begin
                if (pending) begin
                    check("resp_error", {31'b0, resp_error}, {31'b0, e_err});
                    check("resp_rdata", resp_rdata, e_rdata);
                    check("resp_cycle", ncyc - acc_n, e_lat);
                    check("mem_done", {30'b0, e_ren, e_wen}, 32'd0);
                    pending = 0;
                    resp_n = ncyc;
                end else check("resp_unexpected", 32'd1, 32'd0);
            end
            if (req_valid && req_ready) begin
                if (pending) check("accept_while_busy", 32'd1, 32'd0);
                m_sz    = (req_funct3[1:0] == 2'd0) ? 1 : (req_funct3[1:0] == 2'd1) ? 2 : 4;
                m_ill   = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7) ||
                          (req_write && (req_funct3 == 3'd4 || req_funct3 == 3'd5));
                e_err   = m_ill || ((req_addr % m_sz) != 0);
                e_idx   = req_addr >> 2;
                m_sh    = 8 * int'(req_addr % 4);
                m_mask  = (m_sz == 1) ? 32'hFF : (m_sz == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
                m_w     = ref_mem[e_idx[5:0]];
                e_rdata = 32'd0;
                e_ren   = 0;
                e_wen   = 0;
                if (e_err) begin
                    e_lat = 1;
                end else if (!req_write) begin
                    e_lat = 2;
                    e_ren = 1;
                    m_v   = (m_w >> m_sh) & m_mask;
                    if (req_funct3 == 3'd0 && m_v[7])  m_v = m_v | 32'hFFFF_FF00;
                    if (req_funct3 == 3'd1 && m_v[15]) m_v = m_v | 32'hFFFF_0000;
                    e_rdata = m_v;
                end else begin
                    e_wen   = 1;
                    e_ren   = (m_sz != 4);
                    e_lat   = (m_sz == 4) ? 2 : 3;
                    e_wdata = (m_w & ~(m_mask << m_sh)) | ((req_wdata & m_mask) << m_sh);
                end
                pending = 1;
                acc_n   = ncyc;
            end
        end
    end

    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        pre_en  = 1'b1;
        pre_idx = idx;
        pre_val = val;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    // Issue one request, wait for acceptance and response; returns the response seen.
    task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input bit hold,
                          output logic [31:0] rd, output logic er);
        bit ok;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        ok = 0;
        rd = 'x;
        er = 'x;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) ok = 1;
        end
        if (!ok) check("accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1 if (!hold) req_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                ok = 1;
                rd = resp_rdata;
                er = resp_error;
            end
        end
        if (!ok) check("resp_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          r1;

    initial begin
        reset = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_funct3 = 3'd0;
        req_addr = '0;
        req_wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp", {29'b0, resp_valid, resp_error, mem_read_enable | mem_write_enable}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_addrs", mem_read_addr | mem_write_addr, 32'd0);
        check("rst_wdata", mem_write_data, 32'd0);
        @(posedge clk);
        #1;

        // SW
        preload(6'd4, 32'h0000_0000);
        do_req(1'b1, F3_W, 32'h10, 32'hDEAD_BEEF, 0, rd, er);
        check("sw_rdata", rd, 32'd0);
        check("sw_err", {31'b0, er}, 32'd0);
        check("sw_mem", mem[4], 32'hDEAD_BEEF);

        // Loads with extension
        preload(6'd4, 32'h80FF_1234);
        do_req(1'b0, F3_B, 32'h13, 32'd0, 0, rd, er);
        check("lb", rd, 32'hFFFF_FF80);
        do_req(1'b0, F3_BU, 32'h13, 32'd0, 0, rd, er);
        check("lbu", rd, 32'h0000_0080);
        do_req(1'b0, F3_H, 32'h12, 32'd0, 0, rd, er);
        check("lh", rd, 32'hFFFF_80FF);
        do_req(1'b0, F3_HU, 32'h12, 32'd0, 0, rd, er);
        check("lhu", rd, 32'h0000_80FF);
        do_req(1'b0, F3_B, 32'h11, 32'd0, 0, rd, er);
        check("lb_pos", rd, 32'h0000_0012);
        do_req(1'b0, F3_W, 32'h10, 32'd0, 0, rd, er);
        check("lw", rd, 32'h80FF_1234);

        // Sub-word stores via read-modify-write
        preload(6'd4, 32'h1122_3344);
        do_req(1'b1, F3_H, 32'h12, 32'h0000_ABCD, 0, rd, er);
        check("sh_mem", mem[4], 32'hABCD_3344);
        preload(6'd4, 32'h1122_3344);
        do_req(1'b1, F3_B, 32'h11, 32'h0000_0055, 0, rd, er);
        check("sb_mem", mem[4], 32'h1122_5544);
        check("sb_rdata", rd, 32'd0);

        // Errors: misaligned, illegal funct3, unsigned store
        do_req(1'b0, F3_W, 32'h06, 32'd0, 0, rd, er);
        check("lw_misaligned", {31'b0, er}, 32'd1);
        check("lw_misaligned_rd", rd, 32'd0);
        do_req(1'b0, 3'b011, 32'h10, 32'd0, 0, rd, er);
        check("f3_011", {31'b0, er}, 32'd1);
        do_req(1'b1, F3_BU, 32'h10, 32'h77, 0, rd, er);
        check("sbu_illegal", {31'b0, er}, 32'd1);
        do_req(1'b1, F3_H, 32'h11, 32'h77, 0, rd, er);
        check("sh_misaligned", {31'b0, er}, 32'd1);
        check("err_mem_unchanged", mem[4], 32'h1122_5544);

        // Reset during the read phase of an SB drops the write
        preload(6'd4, 32'h1122_3344);
        req_write = 1'b1;
        req_funct3 = F3_B;
        req_addr = 32'h11;
        req_wdata = 32'h55;
        req_valid = 1'b1;
        @(negedge clk);
        check("rst_mid_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_mid_ready_after", {31'b0, req_ready}, 32'd1);
        check("rst_mid_resp", {31'b0, resp_valid}, 32'd0);
        repeat (4) @(negedge clk);
        check("rst_mid_mem", mem[4], 32'h1122_3344);
        @(posedge clk);
        #1;

        // Back-to-back loads with req_valid held high
        preload(6'd5, 32'hCAFE_F00D);
        do_req(1'b0, F3_W, 32'h10, 32'd0, 1, rd, er);
        check("b2b_first", rd, 32'h1122_3344);
        r1 = resp_n;
        do_req(1'b0, F3_W, 32'h14, 32'd0, 0, rd, er);
        check("b2b_second", rd, 32'hCAFE_F00D);
        check("b2b_gap", acc_n - r1, 32'd1);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
